// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types, constants and the round-robin pick function for the UART
// transmit arbiter and any other byte-stream arbiter built on rr_arbiter.
//
// Contents:
//   arb_state_t : arbiter FSM state (IDLE, GRANT)
//   BYTE_W      : width of one stream byte
//   MAX_REQ     : largest requester count the pick function handles
//   IDX_W       : index width matching MAX_REQ
//   rr_pick     : round-robin search starting just after 'last', with wrap.
//                 Requesters beyond the real count are removed by 'mask'.
// -----------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int BYTE_W  = 8;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    // Returns the first live request found at last+1, last+2, ... (mod MAX_REQ).
    // Because the mask is a contiguous run of low bits, wrapping at MAX_REQ
    // visits the live requesters in the same order as wrapping at the real
    // requester count. 'last' itself is visited last, so it has lowest priority.
    // Result is undefined-but-harmless (zero) when nothing is live.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   last,
        input logic [MAX_REQ-1:0] mask
    );
        logic [MAX_REQ-1:0] live;
        logic [IDX_W-1:0]   idx;
        logic [IDX_W-1:0]   result;
        logic               found;
        live   = req & mask;
        result = '0;
        found  = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = last + IDX_W'(k);
            if (!found && live[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_if.sv
// -----------------------------------------------------------------------------
// axis_if
// Minimal byte stream handshake: a transfer happens when vld & rdy.
//
// Signals:
//   data : payload, W bits
//   vld  : source has data
//   rdy  : sink can accept
// Modports: master (drives data/vld), slave (drives rdy).
// -----------------------------------------------------------------------------
interface axis_if #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         vld;
    logic         rdy;

    modport master (output data, output vld, input rdy);
    modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Intended for reuse by other
// port arbiters (e.g. a frame-buffer port arbiter).
//
// Parameters:
//   N  : number of requesters (2..8)
//   IW : index width, $clog2(N) with a minimum of 1
// Ports:
//   req  in  N   request bits
//   last in  IW  index granted last time (lowest priority this pick)
//   pick out IW  first set request after 'last', wrapping
//   any  out 1   at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] pick,
    output logic          any
);

    logic [MAX_REQ-1:0] req_wide;
    logic [MAX_REQ-1:0] mask_wide;
    logic [IDX_W-1:0]   last_wide;
    logic [IDX_W-1:0]   pick_wide;

    // Widen the request vector to the function's fixed width; slots with no
    // real requester are tied off and masked.
    genvar gi;
    for (gi = 0; gi < MAX_REQ; gi++) begin : g_pad
        if (gi < N) begin : g_live
            assign req_wide[gi]  = req[gi];
            assign mask_wide[gi] = 1'b1;
        end else begin : g_dead
            assign req_wide[gi]  = 1'b0;
            assign mask_wide[gi] = 1'b0;
        end
    end

    assign last_wide = IDX_W'(last);
    assign pick_wide = rr_pick(req_wide, last_wide, mask_wide);
    assign pick      = IW'(pick_wide);
    assign any       = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
// Shares one UART transmit byte stream between NUM_REQ requesters using
// round-robin arbitration with burst locking: once granted, a requester keeps
// the stream until it has sent MAX_BURST bytes or goes idle while the UART is
// ready. One dead (IDLE) cycle separates consecutive grants.
//
// Build option:
//   UART_ARB_PRIO_EN  defined   : requester 0 wins every pick it requests at;
//                                 the others share round-robin, and the
//                                 pointer moves only on their grants. Grants
//                                 are never pre-empted.
//                     undefined : plain round-robin over all requesters.
//
// Parameters:
//   NUM_REQ   : requester count (2..8)
//   MAX_BURST : bytes per grant before forced re-arbitration (1..255)
// Ports:
//   clk        in   1            system clock
//   rst        in   1            asynchronous, active-low reset
//   req_data   in   NUM_REQ*8    requester i byte at [8i+7:8i]
//   req_vld    in   NUM_REQ      requester byte valid
//   req_rdy    out  NUM_REQ      requester byte accepted when vld & rdy
//   axis_tx    axis_if.master    byte stream towards the UART transmitter
//   grant_vld  out  1            a requester holds the grant
//   grant_id   out  OWN_W        current owner, meaningful when grant_vld
// -----------------------------------------------------------------------------
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 3,
    parameter  int MAX_BURST = 64,
    localparam int OWN_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_vld,
    output logic [NUM_REQ-1:0]        req_rdy,
    axis_if.master                    axis_tx,
    output logic                      grant_vld,
    output logic [OWN_W-1:0]          grant_id
);

    localparam logic [7:0]       BURST_LIMIT = 8'(MAX_BURST);
    localparam logic [OWN_W-1:0] LAST_INIT   = OWN_W'(NUM_REQ - 1);

    arb_state_t         state_reg;
    logic [OWN_W-1:0]   owner_reg;
    logic [OWN_W-1:0]   last_reg;
    logic [7:0]         burst_cnt_reg;
    logic [7:0]         burst_cnt_next;

    logic               in_grant;
    logic               owner_vld;
    logic               tx_ok;
    logic               burst_done;
    logic               owner_gap;

    logic [NUM_REQ-1:0] rr_req;
    logic [OWN_W-1:0]   rr_pick_idx;
    logic               rr_any;
    logic [OWN_W-1:0]   sel_idx;
    logic               sel_any;
    logic               sel_moves_ptr;

    logic [BYTE_W-1:0]  lane [NUM_REQ];

    // ------------------------------------------------------------------
    // Pick logic
    // ------------------------------------------------------------------
    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (OWN_W)
    ) u_rr (
        .req  (rr_req),
        .last (last_reg),
        .pick (rr_pick_idx),
        .any  (rr_any)
    );

`ifdef UART_ARB_PRIO_EN
    // Requester 0 is taken out of the rotation and overrides it. Its grants
    // leave the pointer alone so the others keep their round-robin order.
    always_comb begin
        rr_req    = req_vld;
        rr_req[0] = 1'b0;
    end
    assign sel_idx       = req_vld[0] ? '0 : rr_pick_idx;
    assign sel_any       = req_vld[0] | rr_any;
    assign sel_moves_ptr = ~req_vld[0];
`else
    assign rr_req        = req_vld;
    assign sel_idx       = rr_pick_idx;
    assign sel_any       = rr_any;
    assign sel_moves_ptr = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Output mux towards the UART
    // ------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        localparam logic [OWN_W-1:0] IDX = OWN_W'(gi);
        assign lane[gi]    = req_data[gi*BYTE_W +: BYTE_W];
        // Only the owner ever sees rdy, so at most one bit is high.
        assign req_rdy[gi] = in_grant & (owner_reg == IDX) & axis_tx.rdy;
    end

    assign in_grant       = (state_reg == GRANT);
    assign owner_vld      = req_vld[owner_reg];
    assign tx_ok          = in_grant & owner_vld & axis_tx.rdy;
    assign burst_cnt_next = burst_cnt_reg + 8'd1;
    assign burst_done     = tx_ok && (burst_cnt_next == BURST_LIMIT);
    // Release on an idle owner only when the UART could have taken a byte;
    // while the UART is busy the owner may stall without losing the grant,
    // which also guarantees the owner never changes under vld & !rdy.
    assign owner_gap      = in_grant & axis_tx.rdy & ~owner_vld;

    assign axis_tx.vld    = in_grant & owner_vld;
    assign axis_tx.data   = in_grant ? lane[owner_reg] : '0;
    assign grant_id       = owner_reg;

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            last_reg      <= LAST_INIT;
            burst_cnt_reg <= '0;
            grant_vld     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sel_any) begin
                        state_reg     <= GRANT;
                        owner_reg     <= sel_idx;
                        burst_cnt_reg <= '0;
                        grant_vld     <= 1'b1;
                        if (sel_moves_ptr) begin
                            last_reg <= sel_idx;
                        end
                    end
                end
                GRANT: begin
                    if (tx_ok) begin
                        burst_cnt_reg <= burst_cnt_next;
                    end
                    if (burst_done || owner_gap) begin
                        state_reg <= IDLE;
                        grant_vld <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

    localparam int N  = 3;
    localparam int MB = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*8-1:0]   req_data;
    logic [N-1:0]     req_vld;
    logic [N-1:0]     req_rdy;
    logic             grant_vld;
    logic [1:0]       grant_id;

    int n_cmp = 0;
    int n_err = 0;

    axis_if #(.W(8)) tx_if ();

    uart_tx_arb #(
        .NUM_REQ   (N),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .axis_tx   (tx_if),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled 4
    // units after the edge, well clear of the next edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b0;
        req_vld   = '0;
        req_data  = '0;
        tx_if.rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic int accepted_owner();
        int a = -1;
        for (int i = 0; i < N; i++) begin
            if (req_vld[i] && req_rdy[i]) a = i;
        end
        return a;
    endfunction

    // Reference pick: scan distances 1..N from the last winner.
    function automatic int model_pick(logic [N-1:0] v, int last);
`ifdef UART_ARB_PRIO_EN
        if (v[0]) return 0;
        for (int d = 1; d <= N; d++) begin
            int c = (last + d) % N;
            if (c != 0 && v[c]) return c;
        end
        return -1;
`else
        for (int d = 1; d <= N; d++) begin
            int c = (last + d) % N;
            if (v[c]) return c;
        end
        return -1;
`endif
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst       = 1'b0;
        req_vld   = '1;
        req_data  = 24'hC3B2A1;
        tx_if.rdy = 1'b1;
        #12;
        n_cmp++;
        if (grant_vld !== 1'b0) begin
            n_err++; $display("FAIL reset_grant_vld: got %0b want 0", grant_vld);
        end
        n_cmp++;
        if (grant_id !== 2'd0) begin
            n_err++; $display("FAIL reset_grant_id: got %0d want 0", grant_id);
        end
        n_cmp++;
        if (req_rdy !== 3'b000) begin
            n_err++; $display("FAIL reset_req_rdy: got %b want 000", req_rdy);
        end
        n_cmp++;
        if (tx_if.vld !== 1'b0) begin
            n_err++; $display("FAIL reset_tx_vld: got %0b want 0", tx_if.vld);
        end
        $display("reset: outputs idle");
    endtask

    // ------------------------------------------------------------------
    task automatic test_single();
        logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
        int e_txv [7] = '{0, 1, 1, 0, 1, 0, 0};
        int e_dat [7] = '{0, 'h11, 'h22, 0, 'h33, 0, 0};
        int e_gv  [7] = '{0, 1, 1, 0, 1, 1, 0};
        int idx = 0;
        apply_reset();
        tx_if.rdy = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (idx < 3) begin
                req_vld  = 3'b010;
                req_data = {8'h00, bytes[idx], 8'h00};
            end else begin
                req_vld  = 3'b000;
                req_data = '0;
            end
            #3;
            n_cmp++;
            if (tx_if.vld !== 1'(e_txv[c])) begin
                n_err++; $display("FAIL single_tx_vld c%0d: got %0b want %0d", c, tx_if.vld, e_txv[c]);
            end
            if (e_txv[c] != 0) begin
                n_cmp++;
                if (tx_if.data !== 8'(e_dat[c])) begin
                    n_err++; $display("FAIL single_data c%0d: got %02h want %02h", c, tx_if.data, e_dat[c]);
                end
            end
            n_cmp++;
            if (grant_vld !== 1'(e_gv[c])) begin
                n_err++; $display("FAIL single_grant_vld c%0d: got %0b want %0d", c, grant_vld, e_gv[c]);
            end
            if (e_gv[c] != 0) begin
                n_cmp++;
                if (grant_id !== 2'd1) begin
                    n_err++; $display("FAIL single_grant_id c%0d: got %0d want 1", c, grant_id);
                end
            end
            if (req_vld[1] && req_rdy[1]) begin
                $display("xfer single: owner=1 data=%02h", tx_if.data);
                idx++;
            end
            next_cycle();
        end
        n_cmp++;
        if (idx !== 3) begin
            n_err++; $display("FAIL single_count: got %0d bytes want 3", idx);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_robin();
`ifdef UART_ARB_PRIO_EN
        int e_own [12] = '{-1, 0, 0, -1, 0, 0, -1, 0, 0, -1, 0, 0};
`else
        int e_own [12] = '{-1, 0, 0, -1, 1, 1, -1, 2, 2, -1, 0, 0};
`endif
        int acc;
        apply_reset();
        tx_if.rdy = 1'b1;
        req_vld   = 3'b111;
        req_data  = {8'hA2, 8'hA1, 8'hA0};
        for (int c = 0; c < 12; c++) begin
            #3;
            acc = accepted_owner();
            n_cmp++;
            if (acc !== e_own[c]) begin
                n_err++; $display("FAIL rr_owner c%0d: got %0d want %0d", c, acc, e_own[c]);
            end
            n_cmp++;
            if ($countones(req_rdy) > 1) begin
                n_err++; $display("FAIL rr_onehot c%0d: got %b want at most one bit", c, req_rdy);
            end
            if (e_own[c] >= 0) begin
                n_cmp++;
                if (tx_if.data !== 8'(160 + e_own[c])) begin
                    n_err++; $display("FAIL rr_data c%0d: got %02h want %02h", c, tx_if.data, 160 + e_own[c]);
                end
                n_cmp++;
                if (grant_id !== 2'(e_own[c])) begin
                    n_err++; $display("FAIL rr_grant_id c%0d: got %0d want %0d", c, grant_id, e_own[c]);
                end
            end
            if (acc >= 0) $display("xfer rr: owner=%0d data=%02h", acc, tx_if.data);
            next_cycle();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall();
        int n0 = 0;
        int acc;
        int e_acc;
        int e_gv;
        int e_gid;
        apply_reset();
        for (int c = 0; c < 15; c++) begin
            if (c <= 1) begin
                req_vld = 3'b001; tx_if.rdy = 1'b1;
            end else if (c <= 11) begin
                req_vld = 3'b110; tx_if.rdy = 1'b0;
            end else if (c == 12) begin
                req_vld = 3'b111; tx_if.rdy = 1'b1;
            end else begin
                req_vld = 3'b110; tx_if.rdy = 1'b1;
            end
            req_data = {8'h62, 8'h61, 8'(8'h50 + n0)};
            e_acc = (c == 1 || c == 12) ? 0 : (c == 14) ? 1 : -1;
            e_gv  = (c == 0 || c == 13) ? 0 : 1;
            e_gid = (c == 14) ? 1 : 0;
            #3;
            acc = accepted_owner();
            n_cmp++;
            if (acc !== e_acc) begin
                n_err++; $display("FAIL stall_owner c%0d: got %0d want %0d", c, acc, e_acc);
            end
            n_cmp++;
            if (grant_vld !== 1'(e_gv)) begin
                n_err++; $display("FAIL stall_grant_vld c%0d: got %0b want %0d", c, grant_vld, e_gv);
            end
            if (e_gv != 0) begin
                n_cmp++;
                if (grant_id !== 2'(e_gid)) begin
                    n_err++; $display("FAIL stall_grant_id c%0d: got %0d want %0d", c, grant_id, e_gid);
                end
            end
            if (c >= 2 && c <= 11) begin
                n_cmp++;
                if (req_rdy !== 3'b000 || tx_if.vld !== 1'b0) begin
                    n_err++; $display("FAIL stall_quiet c%0d: got rdy=%b vld=%0b want 000/0", c, req_rdy, tx_if.vld);
                end
            end
            if (e_acc == 0) begin
                n_cmp++;
                if (tx_if.data !== 8'(8'h50 + n0)) begin
                    n_err++; $display("FAIL stall_data c%0d: got %02h want %02h", c, tx_if.data, 8'h50 + n0);
                end
            end
            if (acc >= 0) $display("xfer stall: owner=%0d data=%02h", acc, tx_if.data);
            if (req_vld[0] && req_rdy[0]) n0++;
            next_cycle();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        apply_reset();
        req_data  = {8'h93, 8'h92, 8'h91};
        req_vld   = 3'b100;
        tx_if.rdy = 1'b1;
        next_cycle();
        next_cycle();                 // requester 2 has sent one byte
        tx_if.rdy = 1'b0;             // UART busy mid-burst
        #3;
        n_cmp++;
        if (grant_vld !== 1'b1 || tx_if.vld !== 1'b1 || grant_id !== 2'd2) begin
            n_err++; $display("FAIL areset_pre: got gv=%0b vld=%0b id=%0d want 1/1/2", grant_vld, tx_if.vld, grant_id);
        end
        #2;
        rst = 1'b0;                   // between clock edges
        #1;
        n_cmp++;
        if (grant_vld !== 1'b0) begin
            n_err++; $display("FAIL areset_grant_vld: got %0b want 0", grant_vld);
        end
        n_cmp++;
        if (tx_if.vld !== 1'b0) begin
            n_err++; $display("FAIL areset_tx_vld: got %0b want 0", tx_if.vld);
        end
        n_cmp++;
        if (req_rdy !== 3'b000 || grant_id !== 2'd0) begin
            n_err++; $display("FAIL areset_rdy_id: got rdy=%b id=%0d want 000/0", req_rdy, grant_id);
        end
        req_vld   = 3'b111;
        tx_if.rdy = 1'b1;
        #1;
        rst = 1'b1;
        next_cycle();
        #3;
        n_cmp++;
        if (grant_vld !== 1'b1 || grant_id !== 2'd0 || accepted_owner() !== 0) begin
            n_err++; $display("FAIL areset_first_pick: got gv=%0b id=%0d acc=%0d want 1/0/0", grant_vld, grant_id, accepted_owner());
        end
        $display("xfer areset: owner=%0d data=%02h", accepted_owner(), tx_if.data);
        next_cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_prio_order();
`ifdef UART_ARB_PRIO_EN
        int e_own [9] = '{-1, 1, 1, -1, 0, 0, -1, 2, 2};
`else
        int e_own [9] = '{-1, 1, 1, -1, 2, 2, -1, 0, 0};
`endif
        int rem [3] = '{2, 2, 2};
        int acc;
        apply_reset();
        tx_if.rdy = 1'b1;
        req_data  = {8'hC2, 8'hC1, 8'hC0};
        for (int c = 0; c < 9; c++) begin
            req_vld[0] = (c >= 1) && (rem[0] > 0);
            req_vld[1] = (rem[1] > 0);
            req_vld[2] = (rem[2] > 0);
            #3;
            acc = accepted_owner();
            n_cmp++;
            if (acc !== e_own[c]) begin
                n_err++; $display("FAIL prio_owner c%0d: got %0d want %0d", c, acc, e_own[c]);
            end
            if (acc >= 0) begin
                $display("xfer prio: owner=%0d data=%02h", acc, tx_if.data);
                rem[acc]--;
            end
            next_cycle();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random(input int cycles);
        int         m_owner = -1;
        int         m_last  = N - 1;
        int         m_cnt   = 0;
        int         m_pops  [N];
        int         d_pops  [N];
        int         p;
        int         vthr;
        int         rthr;
        logic [7:0] head    [N];
        logic [N-1:0] exp_rdy;
        logic       exp_vld;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            head[i]   = 8'($urandom);
            m_pops[i] = 0;
            d_pops[i] = 0;
        end
        for (int c = 0; c < cycles; c++) begin
            vthr = ((c / 700) % 3 == 0) ? 2 : 8;
            rthr = ((c / 500) % 2 == 0) ? 5 : 9;
            for (int i = 0; i < N; i++) begin
                req_vld[i] = ($urandom_range(0, 9) < vthr);
                req_data[i*8 +: 8] = head[i];
            end
            tx_if.rdy = ($urandom_range(0, 9) < rthr);
            #3;
            exp_rdy = '0;
            exp_vld = 1'b0;
            if (m_owner >= 0) begin
                exp_rdy[m_owner] = tx_if.rdy;
                exp_vld = req_vld[m_owner];
            end
            n_cmp++;
            if (req_rdy !== exp_rdy) begin
                n_err++; $display("FAIL rand_req_rdy c%0d: got %b want %b", c, req_rdy, exp_rdy);
            end
            n_cmp++;
            if (grant_vld !== (m_owner >= 0)) begin
                n_err++; $display("FAIL rand_grant_vld c%0d: got %0b want %0b", c, grant_vld, m_owner >= 0);
            end
            n_cmp++;
            if (tx_if.vld !== exp_vld) begin
                n_err++; $display("FAIL rand_tx_vld c%0d: got %0b want %0b", c, tx_if.vld, exp_vld);
            end
            n_cmp++;
            if ($countones(req_rdy) > 1) begin
                n_err++; $display("FAIL rand_onehot c%0d: got %b want at most one bit", c, req_rdy);
            end
            if (m_owner >= 0) begin
                n_cmp++;
                if (grant_id !== 2'(m_owner)) begin
                    n_err++; $display("FAIL rand_grant_id c%0d: got %0d want %0d", c, grant_id, m_owner);
                end
                if (exp_vld) begin
                    n_cmp++;
                    if (tx_if.data !== head[m_owner]) begin
                        n_err++; $display("FAIL rand_data c%0d: got %02h want %02h", c, tx_if.data, head[m_owner]);
                    end
                end
            end
            // Reference model: advance one clock.
            if (m_owner < 0) begin
                p = model_pick(req_vld, m_last);
                if (p >= 0) begin
                    m_owner = p;
                    m_cnt   = 0;
`ifdef UART_ARB_PRIO_EN
                    if (p != 0) m_last = p;
`else
                    m_last = p;
`endif
                end
            end else if (req_vld[m_owner] && tx_if.rdy) begin
                m_pops[m_owner]++;
                m_cnt++;
                if (m_cnt == MB) m_owner = -1;
            end else if (tx_if.rdy) begin
                m_owner = -1;
            end
            // Requesters pop their head byte on their own handshake.
            for (int i = 0; i < N; i++) begin
                if (req_vld[i] && req_rdy[i]) begin
                    d_pops[i]++;
                    head[i] = 8'($urandom);
                end
            end
            next_cycle();
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (d_pops[i] !== m_pops[i]) begin
                n_err++; $display("FAIL rand_bytes_req%0d: got %0d want %0d", i, d_pops[i], m_pops[i]);
            end
            $display("random: requester %0d moved %0d bytes", i, d_pops[i]);
        end
    endtask

    initial begin
        rst       = 1'b0;
        req_vld   = '0;
        req_data  = '0;
        tx_if.rdy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_async_reset();
        test_prio_order();
        test_random(10000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
